// File: rtl/xbar_pkg.sv
// Shared crossbar types and width helpers.
package xbar_pkg;

  // Index width for NumIn initiators, never narrower than one bit.
  function automatic int unsigned idx_width(int unsigned num_in);
    return (num_in > 1) ? $clog2(num_in) : 1;
  endfunction

  // Pointer width for a FIFO of the given depth, never narrower than one bit.
  function automatic int unsigned ptr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return (depth > 0) ? $clog2(depth + 1) : 1;
  endfunction

  localparam int unsigned DefIdxWidth  = 2;
  localparam int unsigned DefDataWidth = 32;

  // Template entry layout; modules declare a local copy sized by their parameters.
  typedef struct packed {
    logic [DefIdxWidth-1:0]  idx;
    logic [DefDataWidth-1:0] data;
  } tgt_entry_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty flags for a Depth-entry FIFO.
module fifo_ptr_ctrl import xbar_pkg::*; #(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrWidth = ptr_width(Depth),
  localparam int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                pop_i,
  output logic [PtrWidth-1:0] wr_ptr_o,
  output logic [PtrWidth-1:0] rd_ptr_o,
  output logic [CntWidth-1:0] count_o,
  output logic                full_o,
  output logic                empty_o
);

  if (Depth == 0) begin : gen_depth_chk
    $fatal(1, "fifo_ptr_ctrl: Depth must be >= 1");
  end

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  // Next-state pointers (wrap at Depth-1) and occupancy count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(Depth - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop_i) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(Depth - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntWidth'(1);
      2'b01:   count_d = count_q - CntWidth'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CntWidth'(Depth));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/xbar_tgt_buffer.sv
// Elastic buffer behind one crossbar target port; gnt_o depends only on buffer state.
module xbar_tgt_buffer import xbar_pkg::*; #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b0,
  localparam int unsigned IdxWidth = idx_width(NumIn),
  localparam int unsigned PtrWidth = ptr_width(Depth),
  localparam int unsigned CntWidth = cnt_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [IdxWidth-1:0]  idx_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic [IdxWidth-1:0]  idx_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [CntWidth-1:0]  usage_o
);

  if (Depth == 0) begin : gen_depth_chk
    $fatal(1, "xbar_tgt_buffer: Depth must be >= 1");
  end
  if (NumIn == 0) begin : gen_numin_chk
    $fatal(1, "xbar_tgt_buffer: NumIn must be >= 1");
  end

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t              mem_q [Depth];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count;
  logic                full, empty;
  logic                push, bypass, wr_en, rd_en;

  // Grant is a pure function of occupancy, so no combinational path from req_i/gnt_i.
  assign gnt_o  = ~rst_i & ~full;
  assign push   = req_i & gnt_o;
  // Empty fall-through: an entry consumed in the same cycle never touches storage.
  assign bypass = FallThrough & empty & ~rst_i;
  assign wr_en  = push & ~(bypass & gnt_i);
  assign rd_en  = ~rst_i & ~empty & gnt_i;

  fifo_ptr_ctrl #(
    .Depth (Depth)
  ) u_ptr_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (wr_en),
    .pop_i    (rd_en),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= '{idx: idx_i, data: wdata_i};
    end
  end

  // Output mux: head entry when non-empty, optional bypass when empty, zero otherwise.
  always_comb begin
    req_o   = 1'b0;
    idx_o   = '0;
    wdata_o = '0;
    if (!rst_i) begin
      if (!empty) begin
        req_o   = 1'b1;
        idx_o   = mem_q[rd_ptr].idx;
        wdata_o = mem_q[rd_ptr].data;
      end else if (FallThrough) begin
        req_o   = req_i;
        idx_o   = idx_i;
        wdata_o = wdata_i;
      end
    end
  end

  assign usage_o = count;

  // Simulation checks.
  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i) !(wr_en && full))
    else $error("xbar_tgt_buffer: push while full");

  a_head_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (!empty && req_o && !gnt_i) |=> ($stable(idx_o) && $stable(wdata_o) && req_o))
    else $error("xbar_tgt_buffer: head entry changed while stalled");

  a_usage_bound : assert property (@(posedge clk_i) usage_o <= CntWidth'(Depth))
    else $error("xbar_tgt_buffer: usage exceeds Depth");

endmodule

// File: tb/tb_xbar_tgt_buffer.sv
// Directed bench: dut0 without fall-through, dut1 with fall-through, shared stimulus.
module tb_xbar_tgt_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        gnt = 1'b0;
  logic [1:0]  idx = '0;
  logic [31:0] wdata = '0;

  logic        gnt0, req0, gnt1, req1;
  logic [1:0]  idx0, idx1, usage0, usage1;
  logic [31:0] wdata0, wdata1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xbar_tgt_buffer #(
    .NumIn (4), .DataWidth (32), .Depth (2), .FallThrough (1'b0)
  ) dut0 (
    .clk_i (clk), .rst_i (rst), .req_i (req), .gnt_o (gnt0), .idx_i (idx), .wdata_i (wdata),
    .req_o (req0), .gnt_i (gnt), .idx_o (idx0), .wdata_o (wdata0), .usage_o (usage0)
  );

  xbar_tgt_buffer #(
    .NumIn (4), .DataWidth (32), .Depth (2), .FallThrough (1'b1)
  ) dut1 (
    .clk_i (clk), .rst_i (rst), .req_i (req), .gnt_o (gnt1), .idx_i (idx), .wdata_i (wdata),
    .req_o (req1), .gnt_i (gnt), .idx_o (idx1), .wdata_o (wdata1), .usage_o (usage1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      rst = 1'b1; req = 1'b1; idx = 2'd3; wdata = 32'h1234_5678; gnt = 1'b0;
      #1;
      n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL rst_gnt0 got %b want 0", gnt0); end
      n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL rst_req0 got %b want 0", req0); end
      n_cmp++; if (gnt1 !== 1'b0) begin n_err++; $display("FAIL rst_gnt1 got %b want 0", gnt1); end
      n_cmp++; if (req1 !== 1'b0) begin n_err++; $display("FAIL rst_req1 got %b want 0", req1); end
    end
    step();
    rst = 1'b0; req = 1'b0;
    #1;
    n_cmp++; if (usage0 !== 2'd0) begin n_err++; $display("FAIL post_rst_usage0 got %0d want 0", usage0); end
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL post_rst_gnt0 got %b want 1", gnt0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL post_rst_req0 got %b want 0", req0); end
    n_cmp++; if (idx0 !== 2'd0) begin n_err++; $display("FAIL post_rst_idx0 got %0d want 0", idx0); end
    n_cmp++; if (wdata0 !== 32'h0) begin n_err++; $display("FAIL post_rst_wdata0 got %h want 0", wdata0); end
    n_cmp++; if (usage1 !== 2'd0) begin n_err++; $display("FAIL post_rst_usage1 got %0d want 0", usage1); end
  endtask

  task automatic test_single();
    step();
    req = 1'b1; idx = 2'd2; wdata = 32'hDEAD_BEEF; gnt = 1'b1;
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL single_gnt0 got %b want 1", gnt0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL single_req0_c0 got %b want 0", req0); end
    step();
    req = 1'b0;
    #1;
    n_cmp++; if (req0 !== 1'b1) begin n_err++; $display("FAIL single_req0_c1 got %b want 1", req0); end
    n_cmp++; if (idx0 !== 2'd2) begin n_err++; $display("FAIL single_idx0 got %0d want 2", idx0); end
    n_cmp++; if (wdata0 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wdata0 got %h want deadbeef", wdata0); end
    n_cmp++; if (usage0 !== 2'd1) begin n_err++; $display("FAIL single_usage0_c1 got %0d want 1", usage0); end
    step();
    #1;
    n_cmp++; if (usage0 !== 2'd0) begin n_err++; $display("FAIL single_usage0_c2 got %0d want 0", usage0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL single_req0_c2 got %b want 0", req0); end
  endtask

  task automatic test_fill_stall();
    step();
    req = 1'b1; idx = 2'd1; wdata = 32'h0000_00A0; gnt = 1'b0;
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL fill_gnt_a got %b want 1", gnt0); end
    step();
    idx = 2'd3; wdata = 32'h0000_00B0;
    #1;
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL fill_gnt_b got %b want 1", gnt0); end
    n_cmp++; if (req0 !== 1'b1) begin n_err++; $display("FAIL fill_req_c1 got %b want 1", req0); end
    n_cmp++; if (idx0 !== 2'd1) begin n_err++; $display("FAIL fill_head_idx_c1 got %0d want 1", idx0); end
    step();
    idx = 2'd0; wdata = 32'h0000_00C0;
    #1;
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL fill_gnt_c got %b want 0", gnt0); end
    n_cmp++; if (usage0 !== 2'd2) begin n_err++; $display("FAIL fill_usage_full got %0d want 2", usage0); end
    n_cmp++; if (wdata0 !== 32'h0000_00A0) begin n_err++; $display("FAIL fill_head_c2 got %h want a0", wdata0); end
    step();
    #1;
    n_cmp++; if (idx0 !== 2'd1) begin n_err++; $display("FAIL stall_idx_stable got %0d want 1", idx0); end
    n_cmp++; if (wdata0 !== 32'h0000_00A0) begin n_err++; $display("FAIL stall_wdata_stable got %h want a0", wdata0); end
    gnt = 1'b1;
    #1;
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL full_pop_gnt got %b want 0", gnt0); end
    n_cmp++; if (req0 !== 1'b1) begin n_err++; $display("FAIL full_pop_req got %b want 1", req0); end
    step();
    #1;
    n_cmp++; if (usage0 !== 2'd1) begin n_err++; $display("FAIL after_pop_usage got %0d want 1", usage0); end
    n_cmp++; if (gnt0 !== 1'b1) begin n_err++; $display("FAIL after_pop_gnt got %b want 1", gnt0); end
    n_cmp++; if (idx0 !== 2'd3) begin n_err++; $display("FAIL order_b_idx got %0d want 3", idx0); end
    n_cmp++; if (wdata0 !== 32'h0000_00B0) begin n_err++; $display("FAIL order_b_wdata got %h want b0", wdata0); end
    step();
    req = 1'b0;
    #1;
    n_cmp++; if (usage0 !== 2'd1) begin n_err++; $display("FAIL order_c_usage got %0d want 1", usage0); end
    n_cmp++; if (idx0 !== 2'd0) begin n_err++; $display("FAIL order_c_idx got %0d want 0", idx0); end
    n_cmp++; if (wdata0 !== 32'h0000_00C0) begin n_err++; $display("FAIL order_c_wdata got %h want c0", wdata0); end
    step();
    gnt = 1'b0;
    #1;
    n_cmp++; if (usage0 !== 2'd0) begin n_err++; $display("FAIL drain_usage got %0d want 0", usage0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL drain_req got %b want 0", req0); end
  endtask

  task automatic test_fallthrough();
    step();
    rst = 1'b1; req = 1'b0; gnt = 1'b0;
    step();
    rst = 1'b0; req = 1'b1; idx = 2'd1; wdata = 32'h5; gnt = 1'b1;
    #1;
    n_cmp++; if (req1 !== 1'b1) begin n_err++; $display("FAIL ft_req_same got %b want 1", req1); end
    n_cmp++; if (idx1 !== 2'd1) begin n_err++; $display("FAIL ft_idx_same got %0d want 1", idx1); end
    n_cmp++; if (wdata1 !== 32'h5) begin n_err++; $display("FAIL ft_wdata_same got %h want 5", wdata1); end
    n_cmp++; if (gnt1 !== 1'b1) begin n_err++; $display("FAIL ft_gnt got %b want 1", gnt1); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL noft_req_empty got %b want 0", req0); end
    step();
    #1;
    n_cmp++; if (usage1 !== 2'd0) begin n_err++; $display("FAIL ft_consumed_usage got %0d want 0", usage1); end
    gnt = 1'b0;
    #1;
    n_cmp++; if (req1 !== 1'b1) begin n_err++; $display("FAIL ft_req_stall got %b want 1", req1); end
    step();
    req = 1'b0;
    #1;
    n_cmp++; if (usage1 !== 2'd1) begin n_err++; $display("FAIL ft_stored_usage got %0d want 1", usage1); end
    n_cmp++; if (req1 !== 1'b1) begin n_err++; $display("FAIL ft_stored_req got %b want 1", req1); end
    n_cmp++; if (wdata1 !== 32'h5) begin n_err++; $display("FAIL ft_stored_wdata got %h want 5", wdata1); end
  endtask

  task automatic test_reset_mid();
    step();
    rst = 1'b1; req = 1'b0; gnt = 1'b0;
    step();
    rst = 1'b0; req = 1'b1; idx = 2'd2; wdata = 32'h1111_1111;
    step();
    idx = 2'd3; wdata = 32'h2222_2222;
    step();
    req = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (usage0 !== 2'd2) begin n_err++; $display("FAIL mid_pre_usage got %0d want 2", usage0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_req got %b want 0", req0); end
    n_cmp++; if (gnt0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_gnt got %b want 0", gnt0); end
    step();
    rst = 1'b0;
    #1;
    n_cmp++; if (usage0 !== 2'd0) begin n_err++; $display("FAIL mid_post_usage got %0d want 0", usage0); end
    n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL mid_post_req got %b want 0", req0); end
    n_cmp++; if (usage1 !== 2'd0) begin n_err++; $display("FAIL mid_post_usage1 got %0d want 0", usage1); end
    for (int i = 0; i < 3; i++) begin
      step();
      gnt = 1'b1;
      #1;
      n_cmp++; if (req0 !== 1'b0) begin n_err++; $display("FAIL mid_ghost_req[%0d] got %b want 0", i, req0); end
    end
    step();
    req = 1'b1; idx = 2'd1; wdata = 32'h3333_3333; gnt = 1'b0;
    step();
    req = 1'b0;
    #1;
    n_cmp++; if (req0 !== 1'b1) begin n_err++; $display("FAIL mid_new_req got %b want 1", req0); end
    n_cmp++; if (idx0 !== 2'd1) begin n_err++; $display("FAIL mid_new_idx got %0d want 1", idx0); end
    n_cmp++; if (wdata0 !== 32'h3333_3333) begin n_err++; $display("FAIL mid_new_wdata got %h want 33333333", wdata0); end
    n_cmp++; if (usage0 !== 2'd1) begin n_err++; $display("FAIL mid_new_usage got %0d want 1", usage0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_fallthrough();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xbar_tgt_buffer.md
Name: xbar_tgt_buffer

Overview:
- Per-target elastic buffer placed directly downstream of one target port of the simplex crossbar; one instance per crossbar target.
- Consumes the crossbar's request/grant/idx/wdata bundle and stores {idx, wdata} in a small FIFO.
- Re-issues entries to the target (memory bank or next pipeline stage) with a req/gnt handshake.
- Breaks the combinational gnt path back into the crossbar arbiter: gnt_o depends only on buffer state, never on req_i or gnt_i.

Parameters:
- NumIn, 4, number of crossbar initiators; IdxWidth = max(1, $clog2(NumIn)).
- DataWidth, 32, payload width.
- Depth, 2, FIFO entries; must be >= 1; power of two not required.
- FallThrough, 1'b0, when 1 an empty buffer forwards req_i/idx_i/wdata_i combinationally to the outputs.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request from crossbar target side.
- gnt_o  out  1  grant to crossbar; high iff buffer not full.
- idx_i  in  IdxWidth  requesting initiator index.
- wdata_i  in  DataWidth  write data.
- req_o  out  1  request to target.
- gnt_i  in  1  grant from target.
- idx_o  out  IdxWidth  initiator index of head entry.
- wdata_o  out  DataWidth  data of head entry.
- usage_o  out  $clog2(Depth+1)  current entry count.

Behaviour:
- Reset: clk_i and rst_i only; synchronous, active-high.
  - On a cycle with rst_i=1: write/read pointers and count go to 0 at the clock edge.
  - While rst_i=1: gnt_o=0 and req_o=0 (both gated by rst_i).
  - After reset: usage_o=0, req_o=0, gnt_o=1; idx_o/wdata_o are driven 0 while empty.
- Push: req_i && gnt_o. The entry is written at the write pointer on the clock edge.
- Pop: req_o && gnt_i. The read pointer advances on the clock edge.
- Pointer wrap: a pointer at Depth-1 advances to 0.
- Count:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - usage_o is the registered count.
- Full (count==Depth):
  - gnt_o=0, including when a pop happens in the same cycle.
  - A freed slot is granted the following cycle.
  - No same-cycle full pass-through.
- Empty, FallThrough=0:
  - req_o=0.
  - Latency from push to req_o is exactly 1 cycle.
- Empty, FallThrough=1:
  - req_o=req_i, idx_o=idx_i, wdata_o=wdata_i (combinational).
  - If gnt_i=1 in the same cycle: the entry is consumed; no write; count stays 0.
  - If gnt_i=0: the entry is written; count becomes 1.
- Non-empty:
  - req_o=1; idx_o/wdata_o come from the head entry.
  - These outputs stay stable until popped.
- Ordering: strict FIFO; no reordering or dropping.
- Reset mid-operation: all stored entries are discarded; no req_o is issued for them afterwards.
- Illegal inputs: idx_i >= NumIn is not checked; it is stored verbatim.
- Assertions (simulation only):
  - $fatal at elaboration if Depth==0 or NumIn==0.
  - No push while full.
  - Head entry stable while req_o && !gnt_i.
  - usage_o <= Depth.

Decomposition:
- Shared package xbar_pkg:
  - function idx_width(NumIn), returning max(1, $clog2(NumIn)).
  - Packed struct template tgt_entry_t {idx, data}; the module uses a local typedef sized by its parameters.
- One natural sub-module: fifo_ptr_ctrl (Depth), holding pointers, count, full/empty and wrap logic.
- Storage array and fall-through muxing stay in xbar_tgt_buffer.

Test Plan:
- Reset then idle: hold rst_i=1 for 3 cycles with req_i=1.
  - Expect gnt_o=0 and req_o=0 throughout.
  - After release: usage_o=0, gnt_o=1, req_o=0.
- Single transfer, FallThrough=0, Depth=2:
  - Stimulus: push idx=2, wdata=0xDEADBEEF in cycle 0, gnt_i=1.
  - Expect req_o=1 with the same idx/data in cycle 1, usage_o=0 in cycle 2.
- Fill and stall, Depth=2, gnt_i=0:
  - Stimulus: push A, B, C on consecutive cycles.
  - Expect A and B granted, C sees gnt_o=0 and usage_o=2, req_o holds A stable.
  - Release gnt_i: pops A, B in order; C is granted 1 cycle after the first pop.
- Full with simultaneous pop:
  - Stimulus: count=2, gnt_i=1, req_i=1.
  - Expect gnt_o=0 that cycle, usage_o=1 next cycle, gnt_o=1 next cycle.
- Fall-through, FallThrough=1, empty:
  - Stimulus: req_i=1, idx=1, wdata=0x5 with gnt_i=1 → req_o=1 same cycle, usage_o stays 0.
  - Repeat with gnt_i=0 → usage_o=1 next cycle and req_o stays 1.
- Reset mid-stream: with 2 entries stored, pulse rst_i for 1 cycle → usage_o=0 and req_o=0 next cycle; the old entries never reappear.
